// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder block.
package mem_pkg;

    localparam int unsigned MEM_WIDTH_DEF = 32;
    localparam int unsigned MEM_BE_W      = MEM_WIDTH_DEF / 8;
    localparam int unsigned MEM_CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// DEPTH x WIDTH storage with byte-enabled registered write and combinational read.
module mem_array #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW-1:0]      addr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] be,
    output logic [WIDTH-1:0]   rdata
);

    localparam int unsigned BE_W = WIDTH / 8;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(BE_W); b++) begin
                if (be[b]) begin
                    mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed response latency.
// Optional MEM_RESPONDER_MISALIGN_ERR_EN faults accesses with addr[1:0] != 0.
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [WIDTH-1:0]   req_addr,
    input  logic [WIDTH-1:0]   req_wdata,
    input  logic [WIDTH/8-1:0] req_be,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_rdata,
    output logic               rsp_err
);

    localparam int unsigned BE_W = WIDTH / 8;
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned IW   = WIDTH - 2;
    localparam logic [MEM_CNT_W-1:0] CNT_INIT =
        (LATENCY == 0) ? MEM_CNT_W'(0) : MEM_CNT_W'(LATENCY - 1);

    mem_state_t           state_q, state_d;
    logic [MEM_CNT_W-1:0] cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 we_q, we_d;
    logic [WIDTH-1:0]     addr_q, addr_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;
    logic [BE_W-1:0]      be_q, be_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;

    logic                 enter_resp;
    logic                 acc_we;
    logic [WIDTH-1:0]     acc_addr;
    logic [WIDTH-1:0]     acc_wdata;
    logic [BE_W-1:0]      acc_be;
    logic                 acc_err;
    logic                 mem_we;
    logic [WIDTH-1:0]     mem_rdata;

    // With zero latency the commit happens in the accept cycle, so use the live request.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
    end

`ifdef MEM_RESPONDER_MISALIGN_ERR_EN
    assign acc_err = (acc_addr[WIDTH-1:2] >= IW'(DEPTH)) || (acc_addr[1:0] != 2'b00);
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^acc_addr[1:0];
    assign acc_err = (acc_addr[WIDTH-1:2] >= IW'(DEPTH));
`endif

    // A reset in the commit cycle must suppress the store.
    assign mem_we = enter_resp && acc_we && !acc_err && !rst;

    mem_array #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (acc_addr[AW+1:2]),
        .wdata (acc_wdata),
        .be    (acc_be),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        enter_resp  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    ready_d = 1'b0;
                    if (LATENCY == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == MEM_CNT_W'(0)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - MEM_CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    ready_d     = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase

        if (enter_resp) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || acc_we) ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
